// File: rtl/axis_apb_writer.sv
// Packs an AXI-Stream byte stream into 32-bit words and writes each word to an
// APB slave at incrementing addresses, one transfer per Recv_start pulse.
module axis_apb_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h43C1_0000
) (
    input  logic        M_APB_aclk,
    input  logic        M_APB_areset,
    input  logic        Recv_start,
    input  logic [11:0] Recv_Length,
    input  logic [7:0]  S_AXIS_tdata,
    input  logic        S_AXIS_tvalid,
    input  logic        S_AXIS_tkeep,
    input  logic        S_AXIS_tlast,
    output logic        S_AXIS_tready,
    output logic [31:0] M_APB_paddr,
    output logic        M_APB_psel,
    output logic        M_APB_penable,
    output logic        M_APB_pwrite,
    output logic [31:0] M_APB_pwdata,
    input  logic        M_APB_pready,
    input  logic        M_APB_pslverr,
    output logic        Recv_busy,
    output logic        Recv_done,
    output logic        Recv_err,
    output logic        Recv_short,
    output logic [12:0] Recv_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_SETUP   = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t      state_q;
    logic [11:0] len_q;
    logic [12:0] count_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        final_q;
    logic        tready_q;
    logic        psel_q;
    logic        penable_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        short_q;

    logic        handshake_d;
    logic        last_byte_d;
    logic        word_full_d;
    logic        early_last_d;
    logic [31:0] merged_d;
    logic        unused_tkeep;

    assign unused_tkeep = S_AXIS_tkeep;

    // Per-byte decode: lane merge and word/transfer termination conditions.
    always_comb begin
        handshake_d  = S_AXIS_tvalid && tready_q;
        last_byte_d  = S_AXIS_tlast || (count_q == {1'b0, len_q});
        word_full_d  = (count_q[1:0] == 2'b11);
        early_last_d = S_AXIS_tlast && (count_q < {1'b0, len_q});
        merged_d     = data_q | ({24'h00_0000, S_AXIS_tdata} << {count_q[1:0], 3'b000});
    end

    // Transfer FSM; every output is driven straight from a register.
    always_ff @(posedge M_APB_aclk or posedge M_APB_areset) begin
        if (M_APB_areset) begin
            state_q   <= ST_IDLE;
            len_q     <= 12'd0;
            count_q   <= 13'd0;
            addr_q    <= 32'h0000_0000;
            data_q    <= 32'h0000_0000;
            final_q   <= 1'b0;
            tready_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Recv_start) begin
                        len_q    <= Recv_Length;
                        count_q  <= 13'd0;
                        err_q    <= 1'b0;
                        short_q  <= 1'b0;
                        data_q   <= 32'h0000_0000;
                        addr_q   <= BASE_ADDR;
                        final_q  <= 1'b0;
                        tready_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_COLLECT;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (handshake_d) begin
                        data_q  <= merged_d;
                        count_q <= count_q + 13'd1;
                        if (early_last_d) begin
                            short_q <= 1'b1;
                        end else begin
                            short_q <= short_q;
                        end
                        // Word goes out when full or when this was the final byte.
                        if (word_full_d || last_byte_d) begin
                            final_q  <= last_byte_d;
                            tready_q <= 1'b0;
                            psel_q   <= 1'b1;
                            state_q  <= ST_SETUP;
                        end else begin
                            state_q  <= ST_COLLECT;
                        end
                    end else begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (M_APB_pready) begin
                        err_q     <= err_q | M_APB_pslverr;
                        addr_q    <= addr_q + 32'd4;
                        data_q    <= 32'h0000_0000;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (final_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            tready_q <= 1'b1;
                            state_q  <= ST_COLLECT;
                        end
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    tready_q  <= 1'b0;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign S_AXIS_tready = tready_q;
    assign M_APB_paddr   = addr_q;
    assign M_APB_psel    = psel_q;
    assign M_APB_penable = penable_q;
    assign M_APB_pwrite  = psel_q;
    assign M_APB_pwdata  = data_q;
    assign Recv_busy     = busy_q;
    assign Recv_done     = done_q;
    assign Recv_err      = err_q;
    assign Recv_short    = short_q;
    assign Recv_count    = count_q;

endmodule
